uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmit path (TX FIFO write port: wr_uart / w_data / tx_full) among NREQ independent requesters.
- Arbitration is at packet granularity. A granted requester owns the FIFO write port until its last byte is accepted, so bytes from different requesters never interleave on the serial line.
- Sits between message sources (status reporter, debug dump, command echo) and the uart top.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, cycles a granted requester may hold req low mid-packet before its grant is revoked.
- TO_BIT, 11, width of the timeout counter; must satisfy 2^TO_BIT > TIMEOUT.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester "byte valid / packet in progress".
- data  input  8*NREQ  flattened byte buses; requester i uses data[8*i+7:8*i].
- last  input  NREQ  per-requester end-of-packet marker, qualified by req.
- ack  output  NREQ  one-hot pulse: requester's current byte was written to the FIFO this cycle.
- grant  output  NREQ  registered one-hot current owner; all zero when idle.
- busy  output  1  high while in SEND.
- abort_tick  output  1  one-cycle pulse when a grant is revoked by timeout.
- wr_uart  output  1  FIFO write strobe, to uart wr_uart.
- w_data  output  8  FIFO write data, to uart w_data.
- tx_full  input  1  FIFO full, from uart tx_full.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, grant = 0, busy = 0, abort_tick = 0.
  - Priority pointer ptr = NREQ-1, so requester 0 wins first.
  - Timeout counter = 0.
  - Combinational outputs: ack = 0, wr_uart = 0, w_data = 0.
- States: IDLE, SEND.
- IDLE:
  - If req != 0, pick the first i with req[i]=1, scanning from ptr+1 upward modulo NREQ.
  - Next cycle: grant = onehot(i), state = SEND, counter = 0.
  - If req == 0, remain in IDLE.
  - No write occurs in IDLE: wr_uart = 0, ack = 0.
- SEND, with g the granted index (combinational outputs):
  - wr_uart = req[g] & ~tx_full.
  - w_data = data[g] when grant != 0, else 0.
  - ack[g] = wr_uart; all other ack bits are 0.
- SEND transitions:
  - wr_uart & last[g]: next cycle state = IDLE, grant = 0, ptr = g. The same requester cannot win the very next arbitration if another requester is waiting.
  - wr_uart & ~last[g]: stay in SEND, counter = 0.
  - req[g] = 0: counter increments. When counter == TIMEOUT-1 on a req-low cycle, next cycle state = IDLE, grant = 0, ptr = g, and abort_tick pulses for exactly that one cycle.
  - req[g] = 1 & tx_full: stall. The counter holds and no timeout applies, because FIFO backpressure is not a requester fault.
- Latency and throughput:
  - From req rising in IDLE to the first possible wr_uart: 1 cycle.
  - One byte per cycle while the FIFO is not full.
  - One idle cycle between packets for re-arbitration.
- Requester rule: data[g] and last[g] must be stable while req[g]=1 and ack[g]=0. The arbiter does not register data.
- Non-granted requesters:
  - Their req is ignored during SEND and their ack stays 0.
  - They may assert or deassert req freely.
- Simultaneous events:
  - A last byte accepted while other requests are pending: IDLE for one cycle, then grant moves to the next requester after g.
  - A single active requester re-wins after the one IDLE cycle.
- Reset mid-packet: grant drops immediately (asynchronous). A partial packet may already be in the FIFO; the arbiter does not flush it.
- last with req=0 has no effect.

Test Plan:
- Single packet: after reset, req[2]=1 with 3 bytes 0x41,0x42,0x43 and last on the third, tx_full=0 -> grant=0100 one cycle after req, wr_uart high 3 consecutive cycles with w_data 41,42,43, ack[2] pulses 3 times, grant=0 after the last byte.
- Round-robin fairness: req=1111 held, each requester sends 1-byte packets -> grant order 0,1,2,3,0 with exactly one idle cycle between packets; no requester wins twice while another is waiting.
- Backpressure: tx_full=1 for 5 cycles mid-packet for requester 1 -> wr_uart=0 and ack=0 for those 5 cycles, w_data held, no abort_tick; the transfer resumes when tx_full drops.
- Timeout: TIMEOUT=8; requester 3 sends 1 byte without last, then drops req -> abort_tick pulses exactly 8 cycles after req falls, grant=0, and the next arbitration starts from requester 0.
- Non-interleave: requester 0 holds a 4-byte packet while req[1] asserts mid-packet -> no ack[1] and no requester-1 byte until requester 0's last byte, then grant=0010.
- Asynchronous reset: assert reset in the middle of SEND -> grant, busy, wr_uart and ack go to 0 without waiting for a clock edge; after release, requester 0 has first priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port among NREQ requesters.
// Handshake: a byte moves when wr_uart is high; ack[g] mirrors wr_uart for the owner g only.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_BIT  = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   data,
    input  logic [NREQ-1:0]     last,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                abort_tick,
    output logic                wr_uart,
    output logic [7:0]          w_data,
    input  logic                tx_full
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     gidx, gidx_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [NREQ-1:0]   grant_n;
    logic [TO_BIT-1:0] cnt, cnt_n;
    logic              abort_n;

    logic [PW-1:0]     win;
    logic              win_found;
    logic [7:0]        sel_data;
    logic              sel_req;
    logic              sel_last;

    assign busy = (state == SEND);

    always_comb begin
        sel_data = '0;
        sel_req  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == PW'(i)) begin
                sel_data = data[8*i +: 8];
                sel_req  = req[i];
                sel_last = last[i];
            end
        end
    end

    // Scan starts just after the previous owner so it cannot re-win while others wait.
    always_comb begin
        int idx;
        idx       = 0;
        win       = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!win_found && req[idx]) begin
                win       = PW'(idx);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        gidx_n  = gidx;
        grant_n = grant;
        ptr_n   = ptr;
        cnt_n   = cnt;
        abort_n = 1'b0;
        wr_uart = 1'b0;
        w_data  = '0;
        ack     = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = SEND;
                    gidx_n  = win;
                    grant_n = NREQ'(1) << win;
                    cnt_n   = '0;
                end
            end
            SEND: begin
                wr_uart = sel_req & ~tx_full;
                w_data  = (grant != '0) ? sel_data : 8'h00;
                ack     = wr_uart ? (NREQ'(1) << gidx) : '0;
                if (wr_uart) begin
                    if (sel_last) begin
                        state_n = IDLE;
                        grant_n = '0;
                        ptr_n   = gidx;
                    end else begin
                        cnt_n = '0;
                    end
                end else if (!sel_req) begin
                    // Only an absent requester counts toward the timeout; FIFO-full stalls hold.
                    if (cnt == TO_BIT'(TIMEOUT - 1)) begin
                        state_n = IDLE;
                        grant_n = '0;
                        ptr_n   = gidx;
                        abort_n = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + TO_BIT'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gidx       <= '0;
            grant      <= '0;
            ptr        <= PW'(NREQ - 1);
            cnt        <= '0;
            abort_tick <= 1'b0;
        end else begin
            state      <= state_n;
            gidx       <= gidx_n;
            grant      <= grant_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            abort_tick <= abort_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle behavioural model, byte scoreboard and literal checks.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int TO_BIT  = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req     = '0;
    logic [8*NREQ-1:0] data    = '0;
    logic [NREQ-1:0]   last    = '0;
    logic              tx_full = 1'b0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              abort_tick;
    logic              wr_uart;
    logic [7:0]        w_data;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TO_BIT(TO_BIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .last       (last),
        .ack        (ack),
        .grant      (grant),
        .busy       (busy),
        .abort_tick (abort_tick),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .tx_full    (tx_full)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester sources ----------------
    logic [8:0]      src_mem [NREQ][32];
    int              rd_p [NREQ] = '{default: 0};
    int              wr_p [NREQ] = '{default: 0};
    logic [NREQ-1:0] pause = '0;
    logic [NREQ-1:0] ack_s = '0;

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (rd_p[i] < wr_p[i] && !pause[i]) begin
                req[i]          = 1'b1;
                data[8*i +: 8]  = src_mem[i][rd_p[i]][7:0];
                last[i]         = src_mem[i][rd_p[i]][8];
            end else begin
                req[i]  = 1'b0;
                last[i] = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        src_mem[r][wr_p[r]] = {l, b};
        wr_p[r]++;
    endtask

    // Requesters advance to their next byte only after an ack.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++)
            if (ack_s[i] && rd_p[i] < wr_p[i]) rd_p[i]++;
        drive_reqs();
    end

    // ---------------- model + scoreboard ----------------
    logic [7:0]      exp_q[$];
    int              gnt_log[$];
    int              wr_cyc[$];
    int              ack_cnt [NREQ] = '{default: 0};
    int              m_owner = -1;
    int              m_ptr   = NREQ - 1;
    int              m_idle  = 0;
    logic            m_abort = 1'b0;
    int              cyc     = 0;
    logic [NREQ-1:0] prev_grant = '0;

    always @(negedge clk) begin : compare
        logic [NREQ-1:0] e_grant;
        logic [NREQ-1:0] e_ack;
        logic            e_wr;
        logic [7:0]      e_data;
        logic [7:0]      sb;
        bit              found;
        int              ri;
        cyc++;
        if (reset) begin
            m_owner = -1;
            m_ptr   = NREQ - 1;
            m_idle  = 0;
            m_abort = 1'b0;
        end
        e_grant = '0;
        e_wr    = 1'b0;
        e_data  = 8'h00;
        if (m_owner >= 0) begin
            e_grant = NREQ'(1) << m_owner;
            e_wr    = req[m_owner] && !tx_full;
            e_data  = data[8*m_owner +: 8];
        end
        e_ack = e_wr ? e_grant : '0;
        check("grant", grant, e_grant);
        check("busy", busy, m_owner >= 0);
        check("wr_uart", wr_uart, e_wr);
        check("w_data", w_data, e_data);
        check("ack", ack, e_ack);
        check("abort_tick", abort_tick, m_abort);

        ack_s = ack;
        for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < NREQ; i++) if (grant[i]) gnt_log.push_back(i);
        prev_grant = grant;
        if (wr_uart) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("sb_extra_byte", exp_q.size(), 1);
            else begin
                sb = exp_q.pop_front();
                check("sb_byte", w_data, sb);
            end
        end

        if (!reset) begin
            m_abort = 1'b0;
            if (m_owner < 0) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    ri = (m_ptr + k) % NREQ;
                    if (!found && req[ri]) begin
                        found   = 1;
                        m_owner = ri;
                        m_idle  = 0;
                    end
                end
            end else if (e_wr) begin
                if (last[m_owner]) begin
                    m_ptr   = m_owner;
                    m_owner = -1;
                end else begin
                    m_idle = 0;
                end
            end else if (!req[m_owner]) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_abort = 1'b1;
                    m_ptr   = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (rd_p[i] < wr_p[i]) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(all_empty() && grant == '0) && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_idle_budget", all_empty() && grant == '0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int a0, a1, a3;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_ack", ack, 0);
        check("rst_abort", abort_tick, 0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Single packet from requester 2.
        push(2, 8'h41, 0); push(2, 8'h42, 0); push(2, 8'h43, 1);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        drive_reqs();
        tick(1);
        check("t1_grant", grant, 4'b0100);
        check("t1_wr", wr_uart, 1);
        check("t1_first_byte", w_data, 8'h41);
        wait_idle(20);
        check("t1_ack_count", ack_cnt[2], 3);
        check("t1_grant_after", grant, 0);

        // Round-robin fairness from a fresh reset.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        gnt_log.delete();
        wr_cyc.delete();
        push(0, 8'hA0, 1); push(1, 8'hB1, 1); push(2, 8'hC2, 1); push(3, 8'hD3, 1); push(0, 8'hA5, 1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hB1); exp_q.push_back(8'hC2);
        exp_q.push_back(8'hD3); exp_q.push_back(8'hA5);
        drive_reqs();
        wait_idle(40);
        check("t2_grant_count", gnt_log.size(), 5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++) check("t2_grant_order", gnt_log[k], exp_order[k]);
        check("t2_write_count", wr_cyc.size(), 5);
        for (int k = 0; k + 1 < wr_cyc.size(); k++) check("t2_gap", wr_cyc[k+1] - wr_cyc[k], 2);

        // Backpressure on requester 1.
        a1 = ack_cnt[1];
        push(1, 8'h10, 0); push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 1);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
        drive_reqs();
        tick(2);
        tx_full = 1'b1;
        repeat (5) begin
            #1;
            check("t3_stall_wr", wr_uart, 0);
            check("t3_stall_ack", ack, 0);
            check("t3_stall_data", w_data, 8'h11);
            check("t3_stall_abort", abort_tick, 0);
            tick(1);
        end
        tx_full = 1'b0;
        #1;
        check("t3_resume_wr", wr_uart, 1);
        check("t3_resume_data", w_data, 8'h11);
        wait_idle(20);
        check("t3_ack_count", ack_cnt[1] - a1, 4);

        // Timeout on requester 3, then requester 0 wins next.
        a3 = ack_cnt[3];
        push(3, 8'h33, 0); push(3, 8'h34, 1);
        exp_q.push_back(8'h33); exp_q.push_back(8'h50); exp_q.push_back(8'h34);
        drive_reqs();
        tick(2);
        pause[3] = 1'b1;
        drive_reqs();
        #1;
        check("t4_abort_early", abort_tick, 0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("t4_abort", abort_tick, k == 8);
        end
        check("t4_grant_revoked", grant, 0);
        check("t4_busy_revoked", busy, 0);
        push(0, 8'h50, 1);
        pause[3] = 1'b0;
        drive_reqs();
        tick(1);
        check("t4_next_grant", grant, 4'b0001);
        wait_idle(20);
        check("t4_ack_count_r3", ack_cnt[3] - a3, 2);

        // Non-interleave: requester 1 arrives mid-packet of requester 0.
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        push(0, 8'h60, 0); push(0, 8'h61, 0); push(0, 8'h62, 0); push(0, 8'h63, 1);
        exp_q.push_back(8'h60); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        exp_q.push_back(8'h63); exp_q.push_back(8'h70);
        drive_reqs();
        tick(1);
        push(1, 8'h70, 1);
        drive_reqs();
        for (int n = 0; n < 20 && grant != 4'b0010; n++) tick(1);
        check("t5_grant_r1", grant, 4'b0010);
        check("t5_r0_acks", ack_cnt[0] - a0, 4);
        check("t5_r1_acks_before", ack_cnt[1] - a1, 0);
        wait_idle(20);

        // Asynchronous reset mid-packet.
        push(0, 8'h80, 0); push(0, 8'h81, 0); push(0, 8'h82, 1);
        exp_q.push_back(8'h80);
        drive_reqs();
        tick(2);
        #1;
        reset = 1'b1;
        #1;
        check("t6_grant", grant, 0);
        check("t6_busy", busy, 0);
        check("t6_wr_uart", wr_uart, 0);
        check("t6_ack", ack, 0);
        for (int i = 0; i < NREQ; i++) rd_p[i] = wr_p[i];
        drive_reqs();
        check("t6_sb_drained", exp_q.size(), 0);
        tick(1);
        reset = 1'b0;
        push(3, 8'h90, 1); push(0, 8'h91, 1);
        exp_q.push_back(8'h91); exp_q.push_back(8'h90);
        drive_reqs();
        tick(1);
        check("t6_first_after_reset", grant, 4'b0001);
        wait_idle(20);

        check("sb_final_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
